// File: rtl/calc_pkg.sv
// Shared lane indices and FSM state encoding for the operand router.
package calc_pkg;

  localparam int DEST_ALU = 0;
  localparam int DEST_MUL = 1;
  localparam int DEST_DIV = 2;
  localparam int DEST_SQR = 3;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_HOLD = 1'b1;

endpackage

// File: rtl/router_lane.sv
// One destination lane: holds an operand (optionally bit-reversed) until its
// consumer takes it; an empty lane drives zero data.
module router_lane #(
  parameter int WIDTH = 8,
  parameter bit REV   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dst_ready,
  output logic             dst_valid,
  output logic [WIDTH-1:0] dst_data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [WIDTH-1:0] lane_data_s;

  // Operand as this lane stores it
  always_comb begin
    lane_data_s = {WIDTH{1'b0}};
    for (int b = 0; b < WIDTH; b++) begin
      lane_data_s[b] = REV ? load_data[WIDTH-1-b] : load_data[b];
    end
  end

  // Next valid/data: flush beats load, load only ever hits an empty lane
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = {WIDTH{1'b0}};
    end else if (load_en) begin
      valid_d = 1'b1;
      data_d  = lane_data_s;
    end else if (valid_q && dst_ready) begin
      valid_d = 1'b0;
      data_d  = {WIDTH{1'b0}};
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Lane registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dst_valid = valid_q;
  assign dst_data  = data_q;

endmodule

// File: rtl/operand_router.sv
// Routes one operand at a time to a single lane or all lanes and waits in HOLD
// until every loaded lane has been consumed.
module operand_router
  import calc_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter int              NDEST    = 4,
  parameter logic [NDEST-1:0] REV_MASK = 4'b0100,
  localparam int             SELW     = (NDEST > 1) ? $clog2(NDEST) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [WIDTH-1:0]       load_data,
  input  logic [SELW-1:0]        load_sel,
  input  logic                   load_bcast,
  input  logic                   flush,
  output logic [NDEST-1:0]       dst_valid,
  input  logic [NDEST-1:0]       dst_ready,
  output logic [NDEST*WIDTH-1:0] dst_data,
  output logic                   busy,
  output logic                   err_sel
);

  state_t           state_d, state_q;
  logic             err_sel_d, err_sel_q;
  logic             accept_s;
  logic             sel_ok_s;
  logic [NDEST-1:0] lane_load_s;
  logic [NDEST-1:0] pending_s;

  // Ready depends only on registered state, flush and reset, never on dst_ready
  assign load_ready = rst_n && (state_q == ST_IDLE) && !flush;
  assign accept_s   = load_valid && load_ready;
  assign sel_ok_s   = load_bcast || (32'(load_sel) < 32'(NDEST));
  assign pending_s  = dst_valid & ~dst_ready;

  for (genvar g = 0; g < NDEST; g++) begin : g_lane
    assign lane_load_s[g] = accept_s && (load_bcast || (load_sel == SELW'(g)));

    router_lane #(
      .WIDTH (WIDTH),
      .REV   (REV_MASK[g])
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .load_en   (lane_load_s[g]),
      .load_data (load_data),
      .dst_ready (dst_ready[g]),
      .dst_valid (dst_valid[g]),
      .dst_data  (dst_data[g*WIDTH +: WIDTH])
    );
  end

  // FSM next state and the out-of-range select pulse
  always_comb begin
    state_d   = state_q;
    err_sel_d = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      err_sel_d = accept_s && !sel_ok_s;
      case (state_q)
        ST_IDLE: state_d = (accept_s && sel_ok_s) ? ST_HOLD : ST_IDLE;
        ST_HOLD: state_d = (pending_s == {NDEST{1'b0}}) ? ST_IDLE : ST_HOLD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      err_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_sel_q <= err_sel_d;
    end
  end

  assign busy    = (state_q == ST_HOLD);
  assign err_sel = err_sel_q;

endmodule

// File: tb/tb_operand_router.sv
// Directed scenarios plus randomized traffic checked against a lane-level
// behavioural model of the router.
module tb_operand_router;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lv = 1'b0, bc = 1'b0, fl = 1'b0;
  logic [7:0]  ld = 8'h00;
  logic [1:0]  sel = 2'd0;
  logic [3:0]  rdy = 4'h0;
  logic        lr, busy, err;
  logic [3:0]  dv;
  logic [31:0] dd;

  logic        lv3 = 1'b0, bc3 = 1'b0, fl3 = 1'b0;
  logic [7:0]  ld3 = 8'h00;
  logic [1:0]  sel3 = 2'd0;
  logic [2:0]  rdy3 = 3'h0;
  logic        lr3, busy3, err3;
  logic [2:0]  dv3;
  logic [23:0] dd3;

  int n_chk = 0;
  int n_pass = 0;

  bit         m_valid [4];
  logic [7:0] m_data  [4];
  bit         m_err;

  operand_router #(.WIDTH(8), .NDEST(4), .REV_MASK(4'b0100)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(lv), .load_ready(lr), .load_data(ld),
    .load_sel(sel), .load_bcast(bc), .flush(fl), .dst_valid(dv), .dst_ready(rdy),
    .dst_data(dd), .busy(busy), .err_sel(err)
  );

  operand_router #(.WIDTH(8), .NDEST(3), .REV_MASK(3'b100)) dut3 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv3), .load_ready(lr3), .load_data(ld3),
    .load_sel(sel3), .load_bcast(bc3), .flush(fl3), .dst_valid(dv3), .dst_ready(rdy3),
    .dst_data(dd3), .busy(busy3), .err_sel(err3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic bit m_busy();
    return m_valid[0] | m_valid[1] | m_valid[2] | m_valid[3];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = 8'h00;
    end
    m_err = 1'b0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven
  task automatic model_edge();
    bit acc;
    acc = lv && !m_busy() && !fl;
    if (fl) begin
      model_reset();
    end else begin
      m_err = acc && !bc && (int'(sel) >= 4);
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i] && rdy[i]) begin
          m_valid[i] = 1'b0;
          m_data[i]  = 8'h00;
        end
        if (acc && (bc || int'(sel) == i)) begin
          m_valid[i] = 1'b1;
          m_data[i]  = (i == 2) ? rev8(ld) : ld;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0]  ev;
    logic [31:0] ed;
    for (int i = 0; i < 4; i++) begin
      ev[i] = m_valid[i];
      ed[i*8 +: 8] = m_data[i];
    end
    check({tag, ".valid"}, {28'd0, dv}, {28'd0, ev});
    check({tag, ".data"}, dd, ed);
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy()});
    check({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
    check({tag, ".ready"}, {31'd0, lr}, {31'd0, (rst_n && !m_busy() && !fl)});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    model_reset();
    #3;
    check("rst.valid", {28'd0, dv}, 32'd0);
    check("rst.data", dd, 32'd0);
    check("rst.ready", {31'd0, lr}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    #10 rst_n = 1'b1;
    #1 check("rst.release_ready", {31'd0, lr}, 32'd1);

    // Single lane with consumer stalled for three cycles
    lv = 1'b1; sel = 2'd1; ld = 8'h3C;
    cycle("s1.load");
    lv = 1'b0;
    check("s1.dv", {28'd0, dv}, 32'h2);
    check("s1.lane1", {24'd0, dd[15:8]}, 32'h3C);
    for (int k = 0; k < 3; k++) cycle("s1.stall");
    check("s1.held", {24'd0, dd[15:8]}, 32'h3C);
    check("s1.not_ready", {31'd0, lr}, 32'd0);
    rdy = 4'b0010;
    cycle("s1.drain");
    rdy = 4'b0000;
    check("s1.ready_after", {31'd0, lr}, 32'd1);
    check("s1.cleared", dd, 32'd0);

    // Reversed lane
    lv = 1'b1; sel = 2'd2; ld = 8'h01;
    cycle("s2.load");
    lv = 1'b0;
    check("s2.dv", {28'd0, dv}, 32'h4);
    check("s2.lane2", {24'd0, dd[23:16]}, 32'h80);
    rdy = 4'hF;
    cycle("s2.drain");
    rdy = 4'h0;

    // Broadcast, lanes drained one per cycle
    lv = 1'b1; bc = 1'b1; sel = 2'd3; ld = 8'h1E;
    cycle("s3.load");
    lv = 1'b0; bc = 1'b0;
    check("s3.data", dd, 32'h1E781E1E);
    rdy = 4'b0001; cycle("s3.d0");
    rdy = 4'b1000; cycle("s3.d3");
    rdy = 4'b0100; cycle("s3.d2");
    check("s3.busy_mid", {31'd0, busy}, 32'd1);
    rdy = 4'b0010; cycle("s3.d1");
    rdy = 4'b0000;
    check("s3.busy_end", {31'd0, busy}, 32'd0);

    // Out-of-range select on the three-lane instance
    lv3 = 1'b1; sel3 = 2'd3; ld3 = 8'hA5;
    cycle("s4.idle4");
    lv3 = 1'b0;
    check("s4.err", {31'd0, err3}, 32'd1);
    check("s4.dv", {29'd0, dv3}, 32'd0);
    check("s4.busy", {31'd0, busy3}, 32'd0);
    cycle("s4.idle4b");
    check("s4.err_once", {31'd0, err3}, 32'd0);
    check("s4.ready", {31'd0, lr3}, 32'd1);

    // Flush during HOLD with an operand offered
    lv = 1'b1; sel = 2'd3; ld = 8'hAA;
    cycle("s5.load");
    fl = 1'b1; ld = 8'h77; sel = 2'd0;
    #1 check("s5.ready_flush", {31'd0, lr}, 32'd0);
    cycle("s5.flush");
    check("s5.dv", {28'd0, dv}, 32'd0);
    check("s5.dd", dd, 32'd0);
    fl = 1'b0; ld = 8'h55;
    cycle("s5.reload");
    lv = 1'b0;
    check("s5.lane0", {24'd0, dd[7:0]}, 32'h55);
    rdy = 4'hF; cycle("s5.drain"); rdy = 4'h0;

    // Reset between clock edges while holding
    lv = 1'b1; sel = 2'd0; ld = 8'hC3;
    cycle("s6.load");
    lv = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("s6.dv", {28'd0, dv}, 32'd0);
    check("s6.dd", dd, 32'd0);
    check("s6.busy", {31'd0, busy}, 32'd0);
    check("s6.ready_low", {31'd0, lr}, 32'd0);
    check("s6.err", {31'd0, err}, 32'd0);
    #2 rst_n = 1'b1;
    #1 check("s6.ready_after", {31'd0, lr}, 32'd1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      lv  = ($urandom_range(0, 3) != 0);
      bc  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      ld  = 8'($urandom);
      sel = 2'($urandom);
      rdy = 4'($urandom);
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/operand_router.md
OPERAND_ROUTER -- requirements
Module: operand_router

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter NDEST, default 4, number of destination lanes (0=ALU, 1=MUL, 2=DIV, 3=SQR).
REQ-003 SHALL have parameter REV_MASK, NDEST bits, default 4'b0100; set bit = lane receives the operand bit-reversed.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port load_valid, input, 1 bit: an operand is offered.
REQ-008 SHALL have port load_ready, output, 1 bit: the router accepts an operand this cycle.
REQ-009 SHALL have port load_data, input, WIDTH bits: the operand.
REQ-010 SHALL have port load_sel, input, clog2(NDEST) bits (minimum 1): the destination lane index.
REQ-011 SHALL have port load_bcast, input, 1 bit: send to all lanes, with load_sel ignored.
REQ-012 SHALL have port flush, input, 1 bit: synchronous abort.
REQ-013 SHALL have port dst_valid, output, NDEST bits: per-lane operand valid.
REQ-014 SHALL have port dst_ready, input, NDEST bits: per-lane consumer ready.
REQ-015 SHALL have port dst_data, output, NDEST*WIDTH bits: lane i occupies bits [i*WIDTH +: WIDTH].
REQ-016 SHALL have port busy, output, 1 bit: high whenever the FSM is in HOLD.
REQ-017 SHALL have port err_sel, output, 1 bit: one-cycle pulse on an out-of-range load_sel.

Function
REQ-018 SHALL implement a two-state FSM with states IDLE and HOLD.
REQ-019 SHALL drive load_ready = (state==IDLE) && !flush, registered state only, with no combinational path from dst_ready.
REQ-020 SHALL accept an operand on a rising edge where load_valid && load_ready.
REQ-021 On accept, SHALL load each targeted lane with load_data, or bit-reversed load_data when that lane's REV_MASK bit is set, and set its dst_valid; FSM goes to HOLD.
REQ-022 Latency: dst_valid/dst_data SHALL be visible in the cycle after the accept edge.
REQ-023 Targets: all lanes when load_bcast=1; else lane load_sel.
REQ-024 When load_bcast=0 and load_sel>=NDEST, the accept edge SHALL load no lane, pulse err_sel high for exactly the next cycle and leave the FSM in IDLE.
REQ-025 A lane SHALL complete on an edge where dst_valid[i] && dst_ready[i]; its dst_valid then clears and its dst_data becomes 0.
REQ-026 A lane's dst_data SHALL hold stable while its dst_valid is high.
REQ-027 A lane with dst_valid low SHALL drive dst_data 0.
REQ-028 Lanes SHALL complete independently, in any order or simultaneously.
REQ-029 HOLD SHALL go to IDLE on the edge where the last pending lane completes; load_ready is high in the following cycle.
REQ-030 dst_ready on a lane with dst_valid low SHALL be ignored.
REQ-031 flush SHALL, on the edge it is sampled, clear all dst_valid, zero all dst_data, force IDLE and accept nothing, even with load_valid high.
REQ-032 err_sel SHALL be 0 in every cycle other than the one following an out-of-range accept.

Reset
REQ-033 rst_n low SHALL immediately, independent of clk, force state IDLE, dst_valid=0, dst_data=0, err_sel=0 and busy=0.
REQ-034 load_ready SHALL be 0 while rst_n is low and SHALL be 1 in the first cycle after release.
REQ-035 Reset asserted mid-HOLD SHALL discard all pending lanes without any handshake.

Structure
REQ-036 Shared package calc_pkg SHALL hold the lane index constants DEST_ALU=0, DEST_MUL=1, DEST_DIV=2, DEST_SQR=3 and the FSM state type.
REQ-037 One sub-module router_lane (valid bit, data register, optional reverse, handshake) SHALL be instantiated NDEST times by a generate loop, with REV_MASK bit i passed as its parameter.

Verification (WIDTH=8, NDEST=4, REV_MASK=4'b0100 unless stated)
REQ-038 Bench SHALL cover: load_sel=1, data 0x3C, dst_ready[1] low for 3 cycles -> dst_valid=4'b0010 and lane1=0x3C held, load_ready=0; dst_ready[1] high -> lane cleared next cycle, load_ready=1.
REQ-039 Bench SHALL cover: load_sel=2, data 0x01 -> lane2=0x80, dst_valid=4'b0100.
REQ-040 Bench SHALL cover: load_bcast=1, data 0x1E, dst_ready bits raised on different cycles -> lanes 0/1/3=0x1E, lane2=0x78; busy stays high until the last lane completes.
REQ-041 Bench SHALL cover: NDEST=3, load_sel=3 -> err_sel high for exactly 1 cycle, dst_valid=0, busy=0.
REQ-042 Bench SHALL cover: flush with load_valid high during HOLD -> all lanes 0, no accept that edge; operand 0x55 accepted on the next edge.
REQ-043 Bench SHALL cover: rst_n low mid-HOLD between clock edges -> outputs 0 immediately; after release load_ready=1.
